// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline hazard sequencer and the datapath.
// master drives the hazard requests; slave (the sequencer) drives buffer/PC controls.
interface pipe_hazard_ctrl_if;
  logic       i_load_use;
  logic       i_mem_wide;
  logic       i_branch_taken;
  logic       i_int;

  logic       o_pc_en;
  logic [1:0] o_pc_sel;
  logic       o_if_id_en;
  logic       o_id_ex_en;
  logic       o_ex_mem_en;
  logic       o_mem_wb_en;
  logic       o_if_id_flush;
  logic       o_id_ex_flush;
  logic [1:0] o_int_push;
  logic       o_int_ack;
  logic [2:0] o_state;

  modport master (
    output i_load_use, i_mem_wide, i_branch_taken, i_int,
    input  o_pc_en, o_pc_sel, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
           o_if_id_flush, o_id_ex_flush, o_int_push, o_int_ack, o_state
  );

  modport slave (
    input  i_load_use, i_mem_wide, i_branch_taken, i_int,
    output o_pc_en, o_pc_sel, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
           o_if_id_flush, o_id_ex_flush, o_int_push, o_int_ack, o_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, wide memory waits,
// taken branches and the interrupt entry sequence (push PC lo/hi, vector fetch).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RESET      | all buffers frozen, IF/ID and ID/EX loaded with NOPs
// RUN        | normal flow; branch, interrupt accept and load-use handled here
// MEM_WAIT   | pipeline frozen while a wide access completes, then ret_state
// PUSH_LO    | push low half of the return PC
// PUSH_HI    | push high half of the return PC
// INT_VEC    | load PC from the interrupt vector, acknowledge the interrupt
module pipe_hazard_ctrl #(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_RUN      = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_PUSH_LO  = 3'd3,
    ST_PUSH_HI  = 3'd4,
    ST_INT_VEC  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_WAIT - 1);

  localparam logic [1:0] SEL_PC1 = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_VEC = 2'b10;

  localparam logic [1:0] PUSH_NONE = 2'b00;
  localparam logic [1:0] PUSH_LO   = 2'b01;
  localparam logic [1:0] PUSH_HI   = 2'b10;

  state_e           state_q, state_d;
  state_e           ret_state_q, ret_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             int_pend_q, int_pend_d;

  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, int_ack;
  logic [1:0] pc_sel, int_push;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RESET;
      ret_state_q <= ST_RUN;
      cnt_q       <= '0;
      int_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      cnt_q       <= cnt_d;
      int_pend_q  <= int_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_state_d = ret_state_q;
    cnt_d       = cnt_q;
    int_pend_d  = int_pend_q;

    pc_en       = 1'b1;
    pc_sel      = SEL_PC1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    int_push    = PUSH_NONE;
    int_ack     = 1'b0;

    // Requests latch in every live state; only the vector fetch consumes them.
    if (state_q inside {ST_RUN, ST_MEM_WAIT, ST_PUSH_LO, ST_PUSH_HI}) begin
      int_pend_d = int_pend_q | hz.i_int;
    end

    case (state_q)
      ST_RUN: begin
        if (hz.i_mem_wide) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
          cnt_d       = CNT_LOAD;
          ret_state_d = ST_RUN;
          state_d     = ST_MEM_WAIT;
        end else if (hz.i_branch_taken) begin
          pc_sel      = SEL_BR;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (int_pend_q) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = ST_PUSH_LO;
        end else if (hz.i_load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (cnt_q != '0) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ret_state_q;
        end
      end

      ST_PUSH_LO, ST_PUSH_HI: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        // An older wide op still in MEM owns the memory port; wait, then retry the push.
        if (hz.i_mem_wide) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
          cnt_d       = CNT_LOAD;
          ret_state_d = state_q;
          state_d     = ST_MEM_WAIT;
        end else if (state_q == ST_PUSH_LO) begin
          int_push = PUSH_LO;
          state_d  = ST_PUSH_HI;
        end else begin
          int_push = PUSH_HI;
          state_d  = ST_INT_VEC;
        end
      end

      ST_INT_VEC: begin
        pc_sel      = SEL_VEC;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        int_ack     = 1'b1;
        int_pend_d  = hz.i_int;
        state_d     = ST_RUN;
      end

      default: begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = ST_RUN;
      end
    endcase
  end

  assign hz.o_pc_en       = pc_en;
  assign hz.o_pc_sel      = pc_sel;
  assign hz.o_if_id_en    = if_id_en;
  assign hz.o_id_ex_en    = id_ex_en;
  assign hz.o_ex_mem_en   = ex_mem_en;
  assign hz.o_mem_wb_en   = mem_wb_en;
  assign hz.o_if_id_flush = if_id_flush;
  assign hz.o_id_ex_flush = id_ex_flush;
  assign hz.o_int_push    = int_push;
  assign hz.o_int_ack     = int_ack;
  assign hz.o_state       = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with MEM_WAIT=1, one with MEM_WAIT=3.
// Inputs change 1 ns after posedge; outputs are checked on the following negedge.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic rst;

  pipe_hazard_ctrl_if bus1 ();
  pipe_hazard_ctrl_if bus3 ();

  pipe_hazard_ctrl #(.MEM_WAIT(1), .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .hz(bus1.slave));
  pipe_hazard_ctrl #(.MEM_WAIT(3), .CNT_W(2)) dut3 (.clk(clk), .rst(rst), .hz(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // input nibble: {load_use, mem_wide, branch_taken, int}
  localparam logic [3:0] NO = 4'b0000;
  localparam logic [3:0] LU = 4'b1000;
  localparam logic [3:0] MW = 4'b0100;
  localparam logic [3:0] BR = 4'b0010;
  localparam logic [3:0] IN = 4'b0001;

  // {pc_en, pc_sel[2], if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, int_push[2], int_ack}
  localparam logic [11:0] O_RESET  = 12'b0_00_0000_11_00_0;
  localparam logic [11:0] O_RUN    = 12'b1_00_1111_00_00_0;
  localparam logic [11:0] O_LU     = 12'b0_00_0111_01_00_0;
  localparam logic [11:0] O_STALL  = 12'b0_00_0000_00_00_0;
  localparam logic [11:0] O_BR     = 12'b1_01_1111_11_00_0;
  localparam logic [11:0] O_ACC    = 12'b0_00_1111_11_00_0;
  localparam logic [11:0] O_PLO    = 12'b0_00_0111_01_01_0;
  localparam logic [11:0] O_PHI    = 12'b0_00_0111_01_10_0;
  localparam logic [11:0] O_PSTALL = 12'b0_00_0000_01_00_0;
  localparam logic [11:0] O_VEC    = 12'b1_10_1111_11_00_1;

  logic [11:0] obs1, obs3;
  assign obs1 = {bus1.o_pc_en, bus1.o_pc_sel, bus1.o_if_id_en, bus1.o_id_ex_en, bus1.o_ex_mem_en,
                 bus1.o_mem_wb_en, bus1.o_if_id_flush, bus1.o_id_ex_flush, bus1.o_int_push, bus1.o_int_ack};
  assign obs3 = {bus3.o_pc_en, bus3.o_pc_sel, bus3.o_if_id_en, bus3.o_id_ex_en, bus3.o_ex_mem_en,
                 bus3.o_mem_wb_en, bus3.o_if_id_flush, bus3.o_id_ex_flush, bus3.o_int_push, bus3.o_int_ack};

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got state=%0d ctl=%b, want state=%0d ctl=%b",
               tag, got[14:12], got[11:0], exp[14:12], exp[11:0]);
    end
  endtask

  task automatic exp1(input string tag, input logic [2:0] st, input logic [11:0] ctl);
    check_val(tag, {bus1.o_state, obs1}, {st, ctl});
  endtask

  task automatic exp3(input string tag, input logic [2:0] st, input logic [11:0] ctl);
    check_val(tag, {bus3.o_state, obs3}, {st, ctl});
  endtask

  task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b);
    rst = r;
    {bus1.i_load_use, bus1.i_mem_wide, bus1.i_branch_taken, bus1.i_int} = a;
    {bus3.i_load_use, bus3.i_mem_wide, bus3.i_branch_taken, bus3.i_int} = b;
  endtask

  task automatic cyc(input logic r, input logic [3:0] a, input logic [3:0] b);
    @(posedge clk);
    #1;
    drive(r, a, b);
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 4'hF, 4'hF);

    // reset held with every input asserted, then released
    repeat (3) cyc(1'b0, 4'hF, 4'hF);
    exp1("t1_rst", 3'd0, O_RESET);
    exp3("t1_rst3", 3'd0, O_RESET);
    cyc(1'b1, NO, NO);
    exp1("t1_hold", 3'd0, O_RESET);
    cyc(1'b1, NO, NO);
    exp1("t1_run", 3'd1, O_RUN);
    exp3("t1_run3", 3'd1, O_RUN);

    // load-use bubble
    cyc(1'b1, LU, NO);  exp1("t2_lu", 3'd1, O_LU);
    cyc(1'b1, NO, NO);  exp1("t2_after", 3'd1, O_RUN);

    // wide access: MEM_WAIT=1 on dut1, MEM_WAIT=3 on dut3
    cyc(1'b1, MW, MW);  exp1("t3_w0", 3'd1, O_STALL); exp3("t3_w0_3", 3'd1, O_STALL);
    cyc(1'b1, MW, MW);  exp1("t3_w1", 3'd2, O_RUN);   exp3("t3_w1_3", 3'd2, O_STALL);
    cyc(1'b1, NO, MW);  exp1("t3_back", 3'd1, O_RUN); exp3("t3_w2_3", 3'd2, O_STALL);
    cyc(1'b1, NO, MW);  exp3("t3_rel_3", 3'd2, O_RUN);
    cyc(1'b1, NO, NO);  exp3("t3_back_3", 3'd1, O_RUN);

    // branch beats load-use and pending interrupt; interrupt taken next
    cyc(1'b1, IN, NO);      exp1("t4_req", 3'd1, O_RUN);
    cyc(1'b1, LU | BR, NO); exp1("t4_br", 3'd1, O_BR);
    cyc(1'b1, NO, NO);      exp1("t4_acc", 3'd1, O_ACC);
    cyc(1'b1, NO, NO);      exp1("t4_plo", 3'd3, O_PLO);
    cyc(1'b1, NO, NO);      exp1("t4_phi", 3'd4, O_PHI);
    cyc(1'b1, IN, NO);      exp1("t4_vec", 3'd5, O_VEC);
    // new request during INT_VEC survives the clear
    cyc(1'b1, NO, NO);      exp1("t4_reacc", 3'd1, O_ACC);
    cyc(1'b1, NO, NO);      exp1("t4_plo2", 3'd3, O_PLO);
    cyc(1'b1, NO, NO);      exp1("t4_phi2", 3'd4, O_PHI);
    cyc(1'b1, NO, NO);      exp1("t4_vec2", 3'd5, O_VEC);
    cyc(1'b1, NO, NO);      exp1("t4_idle", 3'd1, O_RUN);

    // interrupt pulse arriving during MEM_WAIT
    cyc(1'b1, MW, NO);      exp1("t5_stall", 3'd1, O_STALL);
    cyc(1'b1, MW | IN, NO); exp1("t5_rel", 3'd2, O_RUN);
    cyc(1'b1, NO, NO);      exp1("t5_acc", 3'd1, O_ACC);
    cyc(1'b1, NO, NO);      exp1("t5_plo", 3'd3, O_PLO);
    cyc(1'b1, NO, NO);      exp1("t5_phi", 3'd4, O_PHI);
    cyc(1'b1, NO, NO);      exp1("t5_vec", 3'd5, O_VEC);
    cyc(1'b1, NO, NO);      exp1("t5_idle", 3'd1, O_RUN);

    // wide op blocks PUSH_HI, push retried after the wait
    cyc(1'b1, IN, NO);  exp1("t6_req", 3'd1, O_RUN);
    cyc(1'b1, NO, NO);  exp1("t6_acc", 3'd1, O_ACC);
    cyc(1'b1, NO, NO);  exp1("t6_plo", 3'd3, O_PLO);
    cyc(1'b1, MW, NO);  exp1("t6_phi_blk", 3'd4, O_PSTALL);
    cyc(1'b1, MW, NO);  exp1("t6_rel", 3'd2, O_RUN);
    cyc(1'b1, NO, NO);  exp1("t6_phi", 3'd4, O_PHI);
    cyc(1'b1, NO, NO);  exp1("t6_vec", 3'd5, O_VEC);
    cyc(1'b1, NO, NO);  exp1("t6_idle", 3'd1, O_RUN);

    // reset during PUSH_HI drops the sequence and the pending request
    cyc(1'b1, IN, NO);  exp1("t6r_req", 3'd1, O_RUN);
    cyc(1'b1, NO, NO);  exp1("t6r_acc", 3'd1, O_ACC);
    cyc(1'b1, NO, NO);  exp1("t6r_plo", 3'd3, O_PLO);
    cyc(1'b0, NO, NO);  exp1("t6r_phi", 3'd4, O_PHI);
    cyc(1'b0, NO, NO);  exp1("t6r_rst", 3'd0, O_RESET);
    cyc(1'b1, NO, NO);  exp1("t6r_hold", 3'd0, O_RESET);
    cyc(1'b1, NO, NO);  exp1("t6r_run", 3'd1, O_RUN);
    cyc(1'b1, NO, NO);  exp1("t6r_lost", 3'd1, O_RUN);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
